// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control/redirect/loader inputs toward the fetch unit and
// IF/ID register contents back out.
interface instruction_fetch_if #(
  parameter int PC_WIDTH       = 32,
  parameter int INST_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 10
);
  logic                      enable;
  logic                      stall;
  logic                      flush;
  logic [1:0]                pc_src;
  logic [PC_WIDTH-1:0]       branch_target;
  logic [PC_WIDTH-1:0]       jump_target;
  logic                      prog_we;
  logic [MEM_ADDR_WIDTH-1:0] prog_addr;
  logic [INST_WIDTH-1:0]     prog_data;

  logic [PC_WIDTH-1:0]       pc;
  logic [INST_WIDTH-1:0]     instruction;
  logic [PC_WIDTH-1:0]       pc_plus4;
  logic [5:0]                opcode;
  logic [5:0]                funct;
  logic                      valid;
  logic                      halted;

  modport master (
    output enable, stall, flush, pc_src, branch_target, jump_target,
           prog_we, prog_addr, prog_data,
    input  pc, instruction, pc_plus4, opcode, funct, valid, halted
  );

  modport slave (
    input  enable, stall, flush, pc_src, branch_target, jump_target,
           prog_we, prog_addr, prog_data,
    output pc, instruction, pc_plus4, opcode, funct, valid, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS pipeline stage 1: program counter, word-addressed instruction memory
// with a stopped-mode loader, and the IF/ID register.
module instruction_fetch #(
  parameter int                    PC_WIDTH       = 32,
  parameter int                    INST_WIDTH     = 32,
  parameter int                    MEM_ADDR_WIDTH = 10,
  parameter logic [INST_WIDTH-1:0] HALT_INST      = 32'hFFFF_FFFF
) (
  input logic                clk,
  input logic                reset,
  instruction_fetch_if.slave bus
);
  localparam int                  DEPTH   = 2 ** MEM_ADDR_WIDTH;
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [INST_WIDTH-1:0]     r_mem [0:DEPTH-1];
  logic [PC_WIDTH-1:0]       r_pc;
  logic [INST_WIDTH-1:0]     r_instruction;
  logic [PC_WIDTH-1:0]       r_pc_plus4;
  logic                      r_valid;
  logic                      r_halted;

  logic                      w_advance;
  logic [MEM_ADDR_WIDTH-1:0] w_index;
  logic [INST_WIDTH-1:0]     w_fetch;
  logic [PC_WIDTH-1:0]       w_pc_inc;
  logic [PC_WIDTH-1:0]       w_target;

  assign w_advance = bus.enable & ~r_halted;
  // Byte offset and bits above the memory depth are dropped, so the index wraps.
  assign w_index   = r_pc[MEM_ADDR_WIDTH+1:2];
  assign w_fetch   = r_mem[w_index];
  assign w_pc_inc  = r_pc + PC_STEP;
  assign w_target  = (bus.pc_src == 2'b01) ? bus.branch_target : bus.jump_target;

  // Loader port; memory is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (bus.prog_we && !bus.enable) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= '0;
      r_instruction <= '0;
      r_pc_plus4    <= '0;
      r_valid       <= 1'b0;
      r_halted      <= 1'b0;
    end else if (w_advance) begin
      if (bus.pc_src != 2'b00) begin
        r_pc          <= w_target;
        r_instruction <= '0;
        r_pc_plus4    <= '0;
        r_valid       <= 1'b0;
      end else if (bus.flush) begin
        r_pc          <= w_pc_inc;
        r_instruction <= '0;
        r_pc_plus4    <= '0;
        r_valid       <= 1'b0;
      end else if (!bus.stall) begin
        r_instruction <= w_fetch;
        r_pc_plus4    <= w_pc_inc;
        r_valid       <= 1'b1;
        // A halt word is still delivered to decode, but the PC parks on it.
        if (w_fetch == HALT_INST) begin
          r_halted <= 1'b1;
        end else begin
          r_pc <= w_pc_inc;
        end
      end
    end
  end

  assign bus.pc          = r_pc;
  assign bus.instruction = r_instruction;
  assign bus.pc_plus4    = r_pc_plus4;
  assign bus.opcode      = r_instruction[31:26];
  assign bus.funct       = r_instruction[5:0];
  assign bus.valid       = r_valid;
  assign bus.halted      = r_halted;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: load, run, halt, stall,
// redirect, flush, PC/index wrap and asynchronous reset.
module tb_instruction_fetch;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and return at the following falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    @(negedge clk);
    $display("[%0t] %-10s pc=%08h instr=%08h pc4=%08h valid=%0b halted=%0b",
             $time, tag, bus.pc, bus.instruction, bus.pc_plus4, bus.valid, bus.halted);
  endtask

  task automatic idle_inputs();
    bus.enable = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.pc_src = 2'b00;
    bus.branch_target = '0; bus.jump_target = '0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step("reset");
    step("reset");
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [9:0] addr, input logic [31:0] data);
    bus.enable = 1'b0; bus.prog_we = 1'b1; bus.prog_addr = addr; bus.prog_data = data;
    step("load");
    bus.prog_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    do_reset();
    n_checks++;
    if ({bus.pc, bus.instruction, bus.pc_plus4, bus.valid, bus.halted, bus.opcode, bus.funct} !== '0) begin
      $display("FAIL reset_state: pc=%h instr=%h pc4=%h valid=%b halted=%b, required all zero",
               bus.pc, bus.instruction, bus.pc_plus4, bus.valid, bus.halted);
      n_fail++;
    end
  endtask

  task automatic test_load();
    load_word(10'd0,    32'h2001_0005);
    load_word(10'd1,    32'h0022_1820);
    load_word(10'd2,    32'hFFFF_FFFF);
    load_word(10'd16,   32'h8C02_0010);
    load_word(10'd17,   32'h0043_2020);
    load_word(10'd18,   32'h0085_3020);
    load_word(10'd1023, 32'h2442_0001);
    step("stopped");
    n_checks++;
    if (bus.pc !== 32'h0 || bus.valid !== 1'b0) begin
      $display("FAIL load_no_advance: pc=%h valid=%b, required pc=0 valid=0", bus.pc, bus.valid);
      n_fail++;
    end
  endtask

  task automatic test_sequential();
    bus.enable = 1'b1;
    step("fetch");
    n_checks++;
    if ({bus.pc, bus.instruction, bus.pc_plus4, bus.valid} !== {32'h4, 32'h2001_0005, 32'h4, 1'b1}) begin
      $display("FAIL seq_fetch0: pc=%h instr=%h pc4=%h valid=%b, required 4/20010005/4/1",
               bus.pc, bus.instruction, bus.pc_plus4, bus.valid);
      n_fail++;
    end
    step("fetch");
    n_checks++;
    if ({bus.instruction, bus.opcode, bus.funct, bus.pc_plus4, bus.pc} !==
        {32'h0022_1820, 6'h00, 6'h20, 32'h8, 32'h8}) begin
      $display("FAIL seq_fetch1: instr=%h op=%h funct=%h pc4=%h pc=%h, required 00221820/00/20/8/8",
               bus.instruction, bus.opcode, bus.funct, bus.pc_plus4, bus.pc);
      n_fail++;
    end
    step("halt");
    n_checks++;
    if ({bus.instruction, bus.valid, bus.halted, bus.pc} !== {32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8}) begin
      $display("FAIL seq_halt: instr=%h valid=%b halted=%b pc=%h, required FFFFFFFF/1/1/8",
               bus.instruction, bus.valid, bus.halted, bus.pc);
      n_fail++;
    end
    bus.pc_src = 2'b10; bus.jump_target = 32'h40;
    step("halted");
    n_checks++;
    if ({bus.pc, bus.halted, bus.instruction} !== {32'h8, 1'b1, 32'hFFFF_FFFF}) begin
      $display("FAIL halt_sticky: pc=%h halted=%b instr=%h, required 8/1/FFFFFFFF",
               bus.pc, bus.halted, bus.instruction);
      n_fail++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.enable = 1'b1;
    step("fetch");
    bus.stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step("stall");
      n_checks++;
      if ({bus.pc, bus.instruction, bus.valid} !== {32'h4, 32'h2001_0005, 1'b1}) begin
        $display("FAIL stall_hold%0d: pc=%h instr=%h valid=%b, required 4/20010005/1",
                 k, bus.pc, bus.instruction, bus.valid);
        n_fail++;
      end
    end
    bus.stall = 1'b0;
    step("resume");
    n_checks++;
    if ({bus.pc, bus.instruction, bus.pc_plus4} !== {32'h8, 32'h0022_1820, 32'h8}) begin
      $display("FAIL stall_resume: pc=%h instr=%h pc4=%h, required 8/00221820/8",
               bus.pc, bus.instruction, bus.pc_plus4);
      n_fail++;
    end
  endtask

  task automatic test_redirect_vs_stall();
    do_reset();
    bus.enable = 1'b1;
    bus.pc_src = 2'b01; bus.branch_target = 32'h40; bus.jump_target = 32'h80; bus.stall = 1'b1;
    // Load attempt while running must be ignored.
    bus.prog_we = 1'b1; bus.prog_addr = 10'd16; bus.prog_data = 32'hDEAD_BEEF;
    step("branch");
    n_checks++;
    if ({bus.pc, bus.valid, bus.instruction} !== {32'h40, 1'b0, 32'h0}) begin
      $display("FAIL branch_over_stall: pc=%h valid=%b instr=%h, required 40/0/0",
               bus.pc, bus.valid, bus.instruction);
      n_fail++;
    end
    bus.pc_src = 2'b00; bus.stall = 1'b0; bus.prog_we = 1'b0;
    step("fetch");
    n_checks++;
    if ({bus.instruction, bus.pc_plus4, bus.pc, bus.valid} !== {32'h8C02_0010, 32'h44, 32'h44, 1'b1}) begin
      $display("FAIL branch_target_fetch: instr=%h pc4=%h pc=%h valid=%b, required 8C020010/44/44/1",
               bus.instruction, bus.pc_plus4, bus.pc, bus.valid);
      n_fail++;
    end
  endtask

  task automatic test_flush();
    bus.flush = 1'b1;
    step("flush");
    n_checks++;
    if ({bus.instruction, bus.valid, bus.pc} !== {32'h0, 1'b0, 32'h48}) begin
      $display("FAIL flush: instr=%h valid=%b pc=%h, required 0/0/48",
               bus.instruction, bus.valid, bus.pc);
      n_fail++;
    end
    bus.flush = 1'b0;
    step("fetch");
    n_checks++;
    if ({bus.instruction, bus.pc_plus4, bus.pc} !== {32'h0085_3020, 32'h4C, 32'h4C}) begin
      $display("FAIL after_flush: instr=%h pc4=%h pc=%h, required 00853020/4C/4C",
               bus.instruction, bus.pc_plus4, bus.pc);
      n_fail++;
    end
    bus.enable = 1'b0;
    step("paused");
    n_checks++;
    if ({bus.pc, bus.instruction, bus.valid} !== {32'h4C, 32'h0085_3020, 1'b1}) begin
      $display("FAIL enable_low_hold: pc=%h instr=%h valid=%b, required 4C/00853020/1",
               bus.pc, bus.instruction, bus.valid);
      n_fail++;
    end
    bus.enable = 1'b1;
  endtask

  task automatic test_jumps();
    bus.pc_src = 2'b10; bus.jump_target = 32'h1000; bus.branch_target = 32'h40;
    step("jump");
    n_checks++;
    if ({bus.pc, bus.valid} !== {32'h1000, 1'b0}) begin
      $display("FAIL jump: pc=%h valid=%b, required 1000/0", bus.pc, bus.valid);
      n_fail++;
    end
    bus.pc_src = 2'b00;
    step("fetch");
    n_checks++;
    if ({bus.instruction, bus.pc, bus.pc_plus4} !== {32'h2001_0005, 32'h1004, 32'h1004}) begin
      $display("FAIL index_wrap: instr=%h pc=%h pc4=%h, required 20010005/1004/1004",
               bus.instruction, bus.pc, bus.pc_plus4);
      n_fail++;
    end
    bus.pc_src = 2'b11; bus.jump_target = 32'h44;
    step("jr");
    bus.pc_src = 2'b00;
    step("fetch");
    n_checks++;
    if ({bus.instruction, bus.pc} !== {32'h0043_2020, 32'h48}) begin
      $display("FAIL jump_register: instr=%h pc=%h, required 00432020/48", bus.instruction, bus.pc);
      n_fail++;
    end
    bus.pc_src = 2'b10; bus.jump_target = 32'hFFFF_FFFC;
    step("jump");
    bus.pc_src = 2'b00;
    step("fetch");
    n_checks++;
    if ({bus.instruction, bus.pc, bus.pc_plus4} !== {32'h2442_0001, 32'h0, 32'h0}) begin
      $display("FAIL pc_wrap: instr=%h pc=%h pc4=%h, required 24420001/0/0",
               bus.instruction, bus.pc, bus.pc_plus4);
      n_fail++;
    end
  endtask

  task automatic test_async_reset();
    step("fetch");
    #2;
    reset = 1'b1;
    #1;
    $display("[%0t] %-10s pc=%08h instr=%08h valid=%0b", $time, "async_rst", bus.pc, bus.instruction, bus.valid);
    n_checks++;
    if ({bus.pc, bus.instruction, bus.pc_plus4, bus.valid, bus.halted, bus.opcode, bus.funct} !== '0) begin
      $display("FAIL async_reset: pc=%h instr=%h pc4=%h valid=%b halted=%b, required all zero",
               bus.pc, bus.instruction, bus.pc_plus4, bus.valid, bus.halted);
      n_fail++;
    end
    @(negedge clk);
    reset = 1'b0;
    step("fetch");
    n_checks++;
    if ({bus.instruction, bus.pc} !== {32'h2001_0005, 32'h4}) begin
      $display("FAIL mem_retained: instr=%h pc=%h, required 20010005/4", bus.instruction, bus.pc);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_load();
    test_sequential();
    test_stall();
    test_redirect_vs_stall();
    test_flush();
    test_jumps();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Pipeline stage 1 of the MIPS core: holds the program counter and an internal word-addressed instruction memory, and drives the IF/ID register that feeds `opcode`/`funct` into `decoder`. Supports program loading while stopped, stall and flush requests from the hazard/branch logic, branch and jump redirects, and a halt instruction that freezes fetch.

## Interface
- `PC_WIDTH`, 32, PC and target width (byte addresses)
- `INST_WIDTH`, 32, instruction width
- `MEM_ADDR_WIDTH`, 10, log2 of instruction memory depth in words
- `HALT_INST`, 32'hFFFF_FFFF, encoding that halts fetch

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `enable`  in  1  1 = run; 0 = stopped/loader mode
- `stall`  in  1  hold PC and IF/ID contents
- `flush`  in  1  replace IF/ID contents with NOP
- `pc_src`  in  2  00 sequential, 01 branch, 10 jump, 11 jump-register
- `branch_target`  in  PC_WIDTH  target for `pc_src`=01
- `jump_target`  in  PC_WIDTH  target for `pc_src`=10 and 11
- `prog_we`  in  1  instruction memory write strobe
- `prog_addr`  in  MEM_ADDR_WIDTH  word address for load
- `prog_data`  in  INST_WIDTH  word to load
- `pc`  out  PC_WIDTH  current fetch address
- `instruction`  out  INST_WIDTH  IF/ID instruction register
- `pc_plus4`  out  PC_WIDTH  IF/ID copy of fetch address + 4
- `opcode`  out  6  `instruction[31:26]`
- `funct`  out  6  `instruction[5:0]`
- `valid`  out  1  IF/ID holds a real fetched instruction
- `halted`  out  1  halt instruction fetched; fetch frozen

## Operation
- Memory: `2**MEM_ADDR_WIDTH` words, combinational read at index `pc[MEM_ADDR_WIDTH+1:2]`; `pc[1:0]` ignored; upper PC bits ignored (index wraps modulo depth). Not cleared by reset.
- Load: `prog_we`=1 with `enable`=0 writes `prog_data` to `prog_addr` at the edge. `prog_we` with `enable`=1 is ignored.
- Advance condition A = `enable` & ~`halted`. With A=0, all registers hold.
- Priority at each edge with A=1, highest first:
  1. Redirect (`pc_src`≠00): `pc` <= target; IF/ID <= NOP (`instruction`=0, `valid`=0); overrides `stall` and halt detection.
  2. `flush`: `pc` <= `pc`+4; IF/ID <= NOP, `valid`=0.
  3. `stall`: `pc`, `instruction`, `pc_plus4`, `valid` hold.
  4. Normal: `instruction` <= mem[pc]; `pc_plus4` <= `pc`+4; `valid` <= 1; `pc` <= `pc`+4.
- Halt: in case 4, if mem[pc] == `HALT_INST`, instruction still latched with `valid`=1, `pc` holds (not incremented), `halted` <= 1. Sticky until reset.
- Arithmetic: `pc`+4 modulo 2**PC_WIDTH (wraps to 0 at top).
- States (implicit): LOAD (`enable`=0), RUN, HALTED. LOAD↔RUN follows `enable`; RUN→HALTED on halt fetch; HALTED→LOAD/RUN only via reset.

## Timing
- Reset (async, immediate): `pc`=0, `instruction`=0, `pc_plus4`=0, `valid`=0, `halted`=0; `opcode`/`funct`=0.
- Fetch latency: instruction at address P appears on `instruction` one edge after `pc`=P.
- Redirect costs one bubble: target instruction on IF/ID two edges after redirect asserted.
- `pc_src`, targets, `stall`, `flush` sampled only at rising edge; no registered handshake.
- Reset mid-run or mid-load: state returns to reset values; a write in progress at the asserting edge is not guaranteed; memory contents otherwise retained.
- `halted` rises the edge the halt word enters IF/ID.

## Test plan
- Reset/load: load words 0x20010005, 0x00221820, 0xFFFFFFFF at addresses 0..2 with `enable`=0 -> `pc`=0, `valid`=0, no advance.
- Sequential run: `enable`=1 -> IF/ID shows 0x20010005 (`pc_plus4`=4), then 0x00221820 (`opcode`=0, `funct`=0x20, `pc_plus4`=8), then 0xFFFFFFFF with `halted`=1, `pc` stuck at 8.
- Stall: assert `stall` 2 cycles after first fetch -> `pc`=4 and `instruction`=0x20010005 held for 2 edges, then resume.
- Redirect vs stall: `pc_src`=01, `branch_target`=0x40, `stall`=1 same edge -> `pc`=0x40, `valid`=0, next edge fetches mem[16].
- Flush: `flush`=1 one edge -> `instruction`=0, `valid`=0, `pc` advanced by 4.
- Wrap/async reset: `jump_target`=0x1000 (MEM_ADDR_WIDTH=10) -> fetches mem[0]; assert `reset` between edges -> all outputs 0 immediately.
